// File: rtl/rob_retire.sv
// rob_retire: in-order retire stage of the reorder buffer.
//
// Reads one ROB row per cycle (synchronous read, 1-cycle latency) at the row
// holding the next head, retires up to COMMIT_WIDTH complete entries in order,
// emits committed-RAT write requests, and turns a retiring mispredicted branch
// into a one-cycle flush with a redirect PC.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   tail_ptr          allocation pointer from rename (MSB = wrap bit)
//   commit_ready      downstream accepts retirement this cycle
//   rd_addr           ROB row to read (combinational, data returns next cycle)
//   rd_*              per-slot fields of the returned row
//   rat_wreq_*        committed-RAT write requests (registered)
//   retire_cnt        entries retired by the last RUN cycle (registered)
//   head_ptr          oldest unretired entry (MSB = wrap bit)
//   flush             one-cycle pipeline flush pulse
//   redirect_pc       fetch target, valid while flush is high
//
// Optional build macro RETIRE_PERF_EN adds perf_instret / perf_cycle (64-bit).

module rob_retire #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned ROB_DEPTH    = 64,
  parameter int unsigned CREG_W       = 5,
  parameter int unsigned PREG_W       = 6,
  parameter int unsigned PC_W         = 64
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [PREG_W:0]                        tail_ptr,
  input  logic                                   commit_ready,
  output logic [PREG_W-$clog2(COMMIT_WIDTH)-1:0] rd_addr,
  input  logic [COMMIT_WIDTH-1:0]                rd_complete,
  input  logic [COMMIT_WIDTH*CREG_W-1:0]         rd_creg,
  input  logic [COMMIT_WIDTH-1:0]                rd_regwrite,
  input  logic [COMMIT_WIDTH-1:0]                rd_is_branch,
  input  logic [COMMIT_WIDTH-1:0]                rd_pd_fail,
  input  logic [COMMIT_WIDTH*PC_W-1:0]           rd_correct_pc,
  output logic [COMMIT_WIDTH-1:0]                rat_wreq_valid,
  output logic [COMMIT_WIDTH*CREG_W-1:0]         rat_wreq_creg,
  output logic [COMMIT_WIDTH*PREG_W-1:0]         rat_wreq_preg,
  output logic [$clog2(COMMIT_WIDTH):0]          retire_cnt,
  output logic [PREG_W:0]                        head_ptr,
  output logic                                   flush,
  output logic [PC_W-1:0]                        redirect_pc
`ifdef RETIRE_PERF_EN
  ,
  output logic [63:0]                            perf_instret,
  output logic [63:0]                            perf_cycle
`endif
);

  localparam int unsigned OFF_W = $clog2(COMMIT_WIDTH);
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam int unsigned PTR_W = PREG_W + 1;
  localparam int unsigned ROW_W = $clog2(ROB_DEPTH / COMMIT_WIDTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [COMMIT_WIDTH-1:0] retire_c;
  logic [CNT_W-1:0]        retire_cnt_c;
  logic                    mispredict_c;
  logic [PC_W-1:0]         mispredict_pc_c;
  logic [PTR_W-1:0]        head_next_c;
  logic [OFF_W-1:0]        off;
  logic [PTR_W-1:0]        occ;

  assign off = head_ptr[OFF_W-1:0];
  // Occupancy via wrap-bit arithmetic: 0 = empty, ROB_DEPTH = full.
  assign occ = tail_ptr - head_ptr;

  // In-order retire selection over the current row.
  always_comb begin : retire_select
    logic             blocked;
    logic [PTR_W-1:0] slot_ptr;
    retire_c        = '0;
    retire_cnt_c    = '0;
    mispredict_c    = 1'b0;
    mispredict_pc_c = '0;
    slot_ptr        = '0;
    blocked         = (state_q != ST_RUN) || !commit_ready;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      slot_ptr = {head_ptr[PREG_W:OFF_W], OFF_W'(i)};
      // Slots below the head offset are already retired; slots at/after
      // tail are unallocated. Neither blocks nor retires.
      if ((OFF_W'(i) >= off) && ((slot_ptr - head_ptr) < occ)) begin
        if (!blocked && rd_complete[i]) begin
          retire_c[i]  = 1'b1;
          retire_cnt_c = retire_cnt_c + CNT_W'(1);
          if (rd_is_branch[i] && rd_pd_fail[i]) begin
            // Mispredicted branch retires itself and squashes younger slots.
            mispredict_c    = 1'b1;
            mispredict_pc_c = rd_correct_pc[i*PC_W +: PC_W];
            blocked         = 1'b1;
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign head_next_c = head_ptr + PTR_W'(retire_cnt_c);
  // Address the row the head will sit in next cycle so its data is ready then.
  assign rd_addr     = ROW_W'(head_next_c[PREG_W-1:OFF_W]);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (mispredict_c) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_REFILL;
      ST_REFILL: state_d = ST_RUN;
      default:   state_d = ST_REFILL;
    endcase
  end

  // State register; REFILL after reset discards the stale first read.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_REFILL;
    else         state_q <= state_d;
  end

  // Head pointer, retire outputs and flush/redirect.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_ptr       <= '0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      retire_cnt     <= '0;
      rat_wreq_valid <= '0;
      rat_wreq_creg  <= '0;
      rat_wreq_preg  <= '0;
    end else begin
      head_ptr   <= head_next_c;
      flush      <= mispredict_c;
      retire_cnt <= retire_cnt_c;
      if (mispredict_c) redirect_pc <= mispredict_pc_c;
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        // creg 0 is hardwired zero and never gets a committed mapping.
        rat_wreq_valid[i] <= retire_c[i] && rd_regwrite[i] &&
                             (rd_creg[i*CREG_W +: CREG_W] != '0);
        rat_wreq_creg[i*CREG_W +: CREG_W] <= rd_creg[i*CREG_W +: CREG_W];
        rat_wreq_preg[i*PREG_W +: PREG_W] <= {head_ptr[PREG_W-1:OFF_W], OFF_W'(i)};
      end
    end
  end

`ifdef RETIRE_PERF_EN
  // Free-running performance counters, wrap modulo 2^64.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_instret <= '0;
      perf_cycle   <= '0;
    end else begin
      perf_instret <= perf_instret + 64'(retire_cnt_c);
      perf_cycle   <= perf_cycle + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: behavioural ROB row memory with 1-cycle read,
// hand-computed expectations per scenario.
module tb_rob_retire;

  localparam int unsigned CW     = 2;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CREG_W = 5;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned PC_W   = 64;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [PREG_W:0]        tail_ptr;
  logic                   commit_ready;
  logic [4:0]             rd_addr;
  logic [CW-1:0]          rd_complete;
  logic [CW*CREG_W-1:0]   rd_creg;
  logic [CW-1:0]          rd_regwrite;
  logic [CW-1:0]          rd_is_branch;
  logic [CW-1:0]          rd_pd_fail;
  logic [CW*PC_W-1:0]     rd_correct_pc;
  logic [CW-1:0]          rat_wreq_valid;
  logic [CW*CREG_W-1:0]   rat_wreq_creg;
  logic [CW*PREG_W-1:0]   rat_wreq_preg;
  logic [1:0]             retire_cnt;
  logic [PREG_W:0]        head_ptr;
  logic                   flush;
  logic [PC_W-1:0]        redirect_pc;

  int checks = 0;
  int errors = 0;

  logic              m_complete [DEPTH];
  logic              m_regwrite [DEPTH];
  logic              m_branch   [DEPTH];
  logic              m_pdfail   [DEPTH];
  logic [CREG_W-1:0] m_creg     [DEPTH];
  logic [PC_W-1:0]   m_pc       [DEPTH];

  rob_retire #(
    .COMMIT_WIDTH(CW), .ROB_DEPTH(DEPTH), .CREG_W(CREG_W), .PREG_W(PREG_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .resetn(resetn), .tail_ptr(tail_ptr), .commit_ready(commit_ready),
    .rd_addr(rd_addr), .rd_complete(rd_complete), .rd_creg(rd_creg),
    .rd_regwrite(rd_regwrite), .rd_is_branch(rd_is_branch), .rd_pd_fail(rd_pd_fail),
    .rd_correct_pc(rd_correct_pc), .rat_wreq_valid(rat_wreq_valid),
    .rat_wreq_creg(rat_wreq_creg), .rat_wreq_preg(rat_wreq_preg),
    .retire_cnt(retire_cnt), .head_ptr(head_ptr), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // ROB row memory with one-cycle synchronous read.
  always @(posedge clk) begin
    for (int i = 0; i < int'(CW); i++) begin
      rd_complete[i]                  <= m_complete[{rd_addr, 1'(i)}];
      rd_regwrite[i]                  <= m_regwrite[{rd_addr, 1'(i)}];
      rd_is_branch[i]                 <= m_branch[{rd_addr, 1'(i)}];
      rd_pd_fail[i]                   <= m_pdfail[{rd_addr, 1'(i)}];
      rd_creg[i*CREG_W +: CREG_W]     <= m_creg[{rd_addr, 1'(i)}];
      rd_correct_pc[i*PC_W +: PC_W]   <= m_pc[{rd_addr, 1'(i)}];
    end
  end

  task automatic set_entry(input int idx, input logic c, input logic rw,
                           input logic [CREG_W-1:0] cr, input logic br,
                           input logic pf, input logic [PC_W-1:0] pc);
    m_complete[idx] = c;  m_regwrite[idx] = rw; m_creg[idx] = cr;
    m_branch[idx]   = br; m_pdfail[idx]   = pf; m_pc[idx]   = pc;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tail_ptr = '0; commit_ready = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) set_entry(k, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    checks++; if (head_ptr !== 7'd0) begin errors++; $display("FAIL reset_head: got %0d exp 0", head_ptr); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", flush); end
    checks++; if (rat_wreq_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b exp 00", rat_wreq_valid); end
    checks++; if (retire_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", retire_cnt); end
    checks++; if (redirect_pc !== 64'd0) begin errors++; $display("FAIL reset_redirect: got %h exp 0", redirect_pc); end
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (head_ptr !== 7'd0 || rat_wreq_valid !== 2'b00 || flush !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle_%0d: head=%0d valid=%b flush=%b exp head=0 valid=00 flush=0",
                 c, head_ptr, rat_wreq_valid, flush);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 4; k++) set_entry(k, 1'b1, 1'b1, CREG_W'(k + 1), 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'd4;
    n = 0;
    while (rat_wreq_valid === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL b2b_timeout: no retire in 20 cycles"); end
    checks++; if (rat_wreq_valid !== 2'b11 || rat_wreq_creg !== {5'd2, 5'd1} || rat_wreq_preg !== {6'd1, 6'd0}) begin
      errors++; $display("FAIL b2b_row0: valid=%b creg=%h preg=%h exp 11/%h/%h",
                         rat_wreq_valid, rat_wreq_creg, rat_wreq_preg, {5'd2, 5'd1}, {6'd1, 6'd0}); end
    checks++; if (retire_cnt !== 2'd2 || head_ptr !== 7'd2) begin
      errors++; $display("FAIL b2b_row0_head: cnt=%0d head=%0d exp 2/2", retire_cnt, head_ptr); end
    @(negedge clk);
    checks++; if (rat_wreq_valid !== 2'b11 || rat_wreq_creg !== {5'd4, 5'd3} || rat_wreq_preg !== {6'd3, 6'd2}) begin
      errors++; $display("FAIL b2b_row1: valid=%b creg=%h preg=%h exp 11/%h/%h",
                         rat_wreq_valid, rat_wreq_creg, rat_wreq_preg, {5'd4, 5'd3}, {6'd3, 6'd2}); end
    checks++; if (retire_cnt !== 2'd2 || head_ptr !== 7'd4) begin
      errors++; $display("FAIL b2b_row1_head: cnt=%0d head=%0d exp 2/4", retire_cnt, head_ptr); end
    @(negedge clk);
    checks++; if (rat_wreq_valid !== 2'b00 || retire_cnt !== 2'd0 || head_ptr !== 7'd4) begin
      errors++; $display("FAIL b2b_empty: valid=%b cnt=%0d head=%0d exp 00/0/4", rat_wreq_valid, retire_cnt, head_ptr); end
  endtask

  task automatic test_partial_complete();
    int n;
    set_entry(4, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, '0);
    set_entry(5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'd6;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rat_wreq_valid !== 2'b00 || retire_cnt !== 2'd0 || head_ptr !== 7'd4) begin
        errors++; $display("FAIL partial_hold_%0d: valid=%b cnt=%0d head=%0d exp 00/0/4",
                           c, rat_wreq_valid, retire_cnt, head_ptr); end
    end
    m_complete[4] = 1'b1;
    n = 0;
    while (rat_wreq_valid === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL partial_timeout: no retire in 20 cycles"); end
    checks++; if (rat_wreq_valid !== 2'b11 || rat_wreq_creg !== {5'd6, 5'd5} || rat_wreq_preg !== {6'd5, 6'd4}) begin
      errors++; $display("FAIL partial_retire: valid=%b creg=%h preg=%h exp 11/%h/%h",
                         rat_wreq_valid, rat_wreq_creg, rat_wreq_preg, {5'd6, 5'd5}, {6'd5, 6'd4}); end
    checks++; if (retire_cnt !== 2'd2 || head_ptr !== 7'd6) begin
      errors++; $display("FAIL partial_head: cnt=%0d head=%0d exp 2/6", retire_cnt, head_ptr); end
  endtask

  task automatic test_mispredict();
    int n;
    set_entry(6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 64'h0000_0000_8000_0040);
    set_entry(7, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'd8;
    n = 0;
    while (rat_wreq_valid === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL mp_timeout: no retire in 20 cycles"); end
    checks++; if (rat_wreq_valid !== 2'b01 || rat_wreq_creg[4:0] !== 5'd7 || rat_wreq_preg[5:0] !== 6'd6) begin
      errors++; $display("FAIL mp_retire: valid=%b creg0=%0d preg0=%0d exp 01/7/6",
                         rat_wreq_valid, rat_wreq_creg[4:0], rat_wreq_preg[5:0]); end
    checks++; if (retire_cnt !== 2'd1 || head_ptr !== 7'd7) begin
      errors++; $display("FAIL mp_head: cnt=%0d head=%0d exp 1/7", retire_cnt, head_ptr); end
    checks++; if (flush !== 1'b1 || redirect_pc !== 64'h0000_0000_8000_0040) begin
      errors++; $display("FAIL mp_flush: flush=%b pc=%h exp 1/80000040", flush, redirect_pc); end
    // Rename squashes everything younger: tail returns to head.
    tail_ptr = head_ptr;
    set_entry(7, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, '0);
    @(negedge clk);
    checks++; if (flush !== 1'b0 || rat_wreq_valid !== 2'b00 || head_ptr !== 7'd7) begin
      errors++; $display("FAIL mp_flush_cycle: flush=%b valid=%b head=%0d exp 0/00/7", flush, rat_wreq_valid, head_ptr); end
    @(negedge clk);
    checks++; if (flush !== 1'b0 || retire_cnt !== 2'd0) begin
      errors++; $display("FAIL mp_refill: flush=%b cnt=%0d exp 0/0", flush, retire_cnt); end
    tail_ptr = 7'd8;
    n = 0;
    while (rat_wreq_valid === 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL mp_resume_timeout: no retire in 20 cycles"); end
    checks++; if (rat_wreq_valid !== 2'b10 || rat_wreq_creg[9:5] !== 5'd9 || rat_wreq_preg[11:6] !== 6'd7) begin
      errors++; $display("FAIL mp_resume: valid=%b creg1=%0d preg1=%0d exp 10/9/7",
                         rat_wreq_valid, rat_wreq_creg[9:5], rat_wreq_preg[11:6]); end
    checks++; if (head_ptr !== 7'd8 || retire_cnt !== 2'd1 || flush !== 1'b0) begin
      errors++; $display("FAIL mp_resume_head: head=%0d cnt=%0d flush=%b exp 8/1/0", head_ptr, retire_cnt, flush); end
  endtask

  task automatic test_wrap();
    int n;
    for (int k = 8; k < 63; k++) set_entry(k, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'd63;
    n = 0;
    while (head_ptr !== 7'd63 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL wrap_drain: head=%0d exp 63 within 100 cycles", head_ptr); end
    set_entry(63, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, '0);
    set_entry(0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'b100_0001;
    n = 0;
    while (retire_cnt === 2'd0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL wrap_timeout: no retire in 20 cycles"); end
    checks++; if (retire_cnt !== 2'd1 || rat_wreq_valid !== 2'b10 || rat_wreq_preg[11:6] !== 6'd63 || rat_wreq_creg[9:5] !== 5'd10) begin
      errors++; $display("FAIL wrap_slot63: cnt=%0d valid=%b preg1=%0d creg1=%0d exp 1/10/63/10",
                         retire_cnt, rat_wreq_valid, rat_wreq_preg[11:6], rat_wreq_creg[9:5]); end
    checks++; if (head_ptr !== 7'b100_0000) begin
      errors++; $display("FAIL wrap_head64: head=%b exp 1000000", head_ptr); end
    @(negedge clk);
    checks++; if (retire_cnt !== 2'd1 || rat_wreq_valid !== 2'b00 || rat_wreq_preg[5:0] !== 6'd0) begin
      errors++; $display("FAIL wrap_slot0_creg0: cnt=%0d valid=%b preg0=%0d exp 1/00/0",
                         retire_cnt, rat_wreq_valid, rat_wreq_preg[5:0]); end
    checks++; if (head_ptr !== 7'b100_0001) begin
      errors++; $display("FAIL wrap_head65: head=%b exp 1000001", head_ptr); end
  endtask

  task automatic test_commit_ready();
    commit_ready = 1'b0;
    set_entry(1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, '0);
    @(negedge clk);
    tail_ptr = 7'b100_0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (retire_cnt !== 2'd0 || rat_wreq_valid !== 2'b00 || head_ptr !== 7'b100_0001) begin
        errors++; $display("FAIL cr_block_%0d: cnt=%0d valid=%b head=%b exp 0/00/1000001",
                           c, retire_cnt, rat_wreq_valid, head_ptr); end
    end
    commit_ready = 1'b1;
    @(negedge clk);
    checks++; if (rat_wreq_valid !== 2'b10 || rat_wreq_creg[9:5] !== 5'd11 || rat_wreq_preg[11:6] !== 6'd1) begin
      errors++; $display("FAIL cr_release: valid=%b creg1=%0d preg1=%0d exp 10/11/1",
                         rat_wreq_valid, rat_wreq_creg[9:5], rat_wreq_preg[11:6]); end
    checks++; if (head_ptr !== 7'b100_0010 || retire_cnt !== 2'd1) begin
      errors++; $display("FAIL cr_head: head=%b cnt=%0d exp 1000010/1", head_ptr, retire_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    int n;
    set_entry(2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 64'h0000_0000_0000_1234);
    @(negedge clk);
    tail_ptr = 7'b100_0011;
    n = 0;
    while (flush !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL rmf_timeout: no flush in 20 cycles"); end
    checks++; if (redirect_pc !== 64'h1234 || rat_wreq_valid !== 2'b01 || head_ptr !== 7'b100_0011) begin
      errors++; $display("FAIL rmf_flush: pc=%h valid=%b head=%b exp 1234/01/1000011",
                         redirect_pc, rat_wreq_valid, head_ptr); end
    resetn = 1'b0;
    tail_ptr = '0;
    @(negedge clk);
    checks++; if (flush !== 1'b0 || head_ptr !== 7'd0 || rat_wreq_valid !== 2'b00 ||
                  retire_cnt !== 2'd0 || redirect_pc !== 64'd0) begin
      errors++; $display("FAIL rmf_reset: flush=%b head=%0d valid=%b cnt=%0d pc=%h exp 0/0/00/0/0",
                         flush, head_ptr, rat_wreq_valid, retire_cnt, redirect_pc); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_complete();
    test_mispredict();
    test_wrap();
    test_commit_ready();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order retire stage; reads ROB rows that rename/writeback write, retires up to COMMIT_WIDTH entries per cycle.
- Emits architectural RAT write requests ({valid, creg, preg}) to the committed RAT.
- Detects mispredicted branches at the head and raises flush/redirect to the frontend, rename and issue.

Parameters:
- COMMIT_WIDTH, 2, entries per ROB row and max retires per cycle (power of 2).
- ROB_DEPTH, 64, total entries (= PREG_NUM); power of 2, multiple of COMMIT_WIDTH.
- CREG_W, 5, architectural register index width.
- PREG_W, 6, log2(ROB_DEPTH); ROB slot index = physical register id.
- PC_W, 64, PC width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- tail_ptr  in  PREG_W+1  allocation pointer from rename, MSB = wrap bit
- commit_ready  in  1  memory/CSR side accepts retirement this cycle
- rd_addr  out  PREG_W-log2(COMMIT_WIDTH)  ROB row index; synchronous read, data returned next cycle
- rd_complete  in  COMMIT_WIDTH  per-slot complete bit of the returned row
- rd_creg  in  COMMIT_WIDTH*CREG_W  per-slot destination creg
- rd_regwrite  in  COMMIT_WIDTH  per-slot writes-register flag
- rd_is_branch  in  COMMIT_WIDTH  per-slot branch/jump flag
- rd_pd_fail  in  COMMIT_WIDTH  per-slot prediction-failed flag
- rd_correct_pc  in  COMMIT_WIDTH*PC_W  per-slot correct target
- rat_wreq_valid  out  COMMIT_WIDTH  RAT write enable per slot
- rat_wreq_creg  out  COMMIT_WIDTH*CREG_W  RAT write index
- rat_wreq_preg  out  COMMIT_WIDTH*PREG_W  RAT write data (retired slot id)
- retire_cnt  out  log2(COMMIT_WIDTH)+1  entries retired this cycle
- head_ptr  out  PREG_W+1  oldest unretired entry, MSB = wrap bit
- flush  out  1  pipeline flush pulse
- redirect_pc  out  PC_W  fetch target, valid with flush

Behaviour:
- Reset (resetn=0 at posedge): head_ptr=0, state=REFILL, flush=0, redirect_pc=0, retire_cnt=0, all rat_wreq_valid=0.
- rd_addr = row of head_ptr_next (combinational), so the row containing head_ptr is on rd_* every RUN cycle; read latency 1.
- States: RUN, FLUSH, REFILL.
- REFILL: retires nothing; next state RUN. Covers the stale read after reset/flush.
- RUN, per slot i of the current row, with off = head_ptr mod COMMIT_WIDTH:
  - slot i is eligible iff i >= off and (row base + i) is strictly before tail_ptr (wrap-bit compare; head==tail incl. wrap bit = empty).
  - slot i retires iff eligible, rd_complete[i]=1, commit_ready=1, every eligible slot j<i retires, and no slot j<i retired with is_branch&pd_fail.
  - Entries are never retired past a row boundary within one cycle.
- Retire outputs:
  - rat_wreq_valid[i] = retires[i] & rd_regwrite[i] & (creg != 0); preg = row base + i.
  - retire_cnt = number of retiring slots.
  - head_ptr += retire_cnt (mod 2*ROB_DEPTH). Partial-row retire leaves the head mid-row and re-reads the same row.
- Mispredict: a retiring slot with is_branch&pd_fail retires itself (RAT write included) and suppresses all younger slots.
  - Registered: next cycle flush=1 for exactly one cycle, redirect_pc = that slot's rd_correct_pc; state RUN->FLUSH.
- FLUSH: retires nothing; flush=1; rename resets tail_ptr to head_ptr this cycle; next state REFILL.
- ROB full (tail == head, wrap bits differ) handled by the wrap compare; no special case.
- commit_ready=0 blocks all retirement that cycle; head holds.
- resetn low mid-flush: reset wins, flush drops the next cycle.

Optional Feature:
- RETIRE_PERF_EN:
  - When defined: adds outputs perf_instret (64, count of retired entries) and perf_cycle (64, cycles since reset).
  - Both counters reset to 0 and wrap modulo 2^64.
- Without the macro: the ports and counters do not exist, with no other behavioural change.

Test Plan:
- Reset, tail_ptr=0 -> head_ptr stays 0, no rat_wreq_valid, flush=0 for 10 cycles.
- tail=4, slots 0–3 complete, regwrite, creg 1,2,3,4 -> cycle A: preg 0,1 written to creg 1,2; cycle A+1: preg 2,3 written to creg 3,4; head_ptr=4.
- tail=2, slot0 incomplete, slot1 complete -> nothing retires; slot0 completes -> both retire the same cycle; head_ptr=2.
- Slot0 branch pd_fail, correct_pc=0x8000_0040, slot1 complete -> only slot0 retires; next cycle flush=1, redirect_pc=0x80000040; REFILL, then resumes.
- head=63, tail wraps to 1 (wrap bit set) -> slot 63 retires alone, then slots 0; head_ptr=0b1_000001; creg0 entries give no RAT write.
- commit_ready=0 with a complete head -> no retire; raise commit_ready -> retire the next cycle.
